// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register block.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and emits 1-cycle SCL rise/fall and START/STOP pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an NREGS x 8 register file and a synchronous host port.
// Define I2C_TGT_AUTOINC_EN to auto-increment the register pointer per data byte.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        IW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [IW-1:0] host_idx,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          bus_wr_stb,
  output logic [IW-1:0] bus_wr_idx,
  output logic          busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [6:0]     shift_q, shift_d;
  logic [6:0]     tx_q, tx_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  wr_idx_q, wr_idx_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           stb_q, stb_d;
  logic           bus_we;
  logic [7:0]     host_rdata_q;
  logic [7:0]     regs_q [NREGS];
  logic [7:0]     rx_byte;
  logic [7:0]     reg_at_ptr;
  logic [IW-1:0]  next_ptr;

  assign rx_byte    = {shift_q, sda_s};
  assign reg_at_ptr = regs_q[ptr_q];

`ifdef I2C_TGT_AUTOINC_EN
  assign next_ptr = ptr_q + IW'(1);
`else
  assign next_ptr = ptr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      wr_idx_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      wr_idx_q <= wr_idx_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      stb_q    <= stb_d;
    end
  end

  // In ACK states bitcnt is 0 before the ACK-clock rise and 1 after it.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    wr_idx_d = wr_idx_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    stb_d    = 1'b0;
    bus_we   = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, REG, WDATA: begin
          shift_d  = rx_byte[6:0];
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == REG) begin
              ptr_d   = rx_byte[IW-1:0];
              state_d = REG_ACK;
            end else begin
              bus_we   = 1'b1;
              stb_d    = 1'b1;
              wr_idx_d = ptr_q;
              ptr_d    = next_ptr;
              state_d  = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RDATA_ACK;
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: bitcnt_d = 3'd1;
        RDATA_ACK: begin
          if (sda_s == I2C_NACK) begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end else begin
            bitcnt_d = 3'd1;
            ptr_d    = next_ptr;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (bitcnt_q == 3'd0) begin
            sda_oe_d = ~I2C_ACK;
          end else begin
            bitcnt_d = '0;
            if (state_q == ADDR_ACK && shift_q[0] == I2C_RW_READ) begin
              state_d  = RDATA;
              tx_d     = reg_at_ptr[6:0];
              sda_oe_d = ~reg_at_ptr[7];
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? REG : WDATA;
            end
          end
        end
        RDATA: begin
          sda_oe_d = ~tx_q[6];
          tx_d     = {tx_q[5:0], 1'b0};
        end
        RDATA_ACK: begin
          if (bitcnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
          end else begin
            bitcnt_d = '0;
            state_d  = RDATA;
            tx_d     = reg_at_ptr[6:0];
            sda_oe_d = ~reg_at_ptr[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is issued last so it wins a same-index collision with the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      host_rdata_q <= '0;
    end else begin
      if (host_we) regs_q[host_idx] <= host_wdata;
      if (bus_we)  regs_q[ptr_q]    <= rx_byte;
      host_rdata_q <= regs_q[host_idx];
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign bus_wr_stb = stb_q;
  assign bus_wr_idx = wr_idx_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench: bit-banged I2C initiator plus a register/pointer reference model.
module tb_i2c_target_regs;

  localparam int         NREGS = 16;
  localparam int         IW    = 4;
  localparam int         Q     = 5;
  localparam logic [6:0] DEV   = 7'h48;
`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scl_drv = 1'b1;
  logic          sda_drv = 1'b1;
  logic          scl_in, sda_in, sda_oe;
  logic          host_we = 1'b0;
  logic [IW-1:0] host_idx = '0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata;
  logic          bus_wr_stb;
  logic [IW-1:0] bus_wr_idx;
  logic          busy;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(DEV), .NREGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_idx   (host_idx),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .bus_wr_stb (bus_wr_stb),
    .bus_wr_idx (bus_wr_idx),
    .busy       (busy)
  );

  int            total = 0;
  int            bad = 0;
  int            stb_cnt = 0;
  int            oe_cnt = 0;
  logic [IW-1:0] last_idx = '0;
  logic [7:0]    mregs [NREGS];
  int            mptr = 0;
  logic [7:0]    wq [$];

  always @(negedge clk) begin
    if (bus_wr_stb) begin
      stb_cnt  = stb_cnt + 1;
      last_idx = bus_wr_idx;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(2*Q); scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic recv_bit(output logic r);
    sda_drv = 1'b1;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q); r = sda_in;
    wait_clk(Q); scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(r);
      b[i] = r;
    end
    send_bit(nack);
  endtask

  task automatic host_write(input int idx, input logic [7:0] d);
    host_we = 1'b1; host_idx = idx[IW-1:0]; host_wdata = d;
    wait_clk(1);
    host_we = 1'b0;
    mregs[idx] = d;
  endtask

  task automatic host_check(input string tag, input int idx);
    host_idx = idx[IW-1:0];
    wait_clk(1);
    check(tag, host_rdata, mregs[idx]);
  endtask

  // Bus write of the bytes in wq; a non-matching address must be ignored.
  task automatic txn_write(input logic [6:0] a, input logic [7:0] idx);
    logic ack;
    logic match;
    match = (a == DEV);
    i2c_start();
    send_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, match ? 0 : 1);
    send_byte(idx, ack);
    check("wr_idx_ack", ack, match ? 0 : 1);
    if (match) begin
      check("wr_busy", busy, 1);
      mptr = idx % NREGS;
      foreach (wq[k]) begin
        send_byte(wq[k], ack);
        check("wr_data_ack", ack, 0);
        mregs[mptr] = wq[k];
        if (AUTOINC) mptr = (mptr + 1) % NREGS;
      end
    end
    i2c_stop();
    check("wr_stop_busy", busy, 0);
  endtask

  task automatic txn_read(input logic [6:0] a, input bit set_ptr, input logic [7:0] idx, input int n);
    logic ack;
    logic [7:0] b;
    logic match;
    match = (a == DEV);
    i2c_start();
    if (set_ptr) begin
      send_byte({DEV, 1'b0}, ack);
      check("rd_waddr_ack", ack, 0);
      send_byte(idx, ack);
      check("rd_idx_ack", ack, 0);
      mptr = idx % NREGS;
      i2c_start();
    end
    send_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, match ? 0 : 1);
    if (match) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(k == n - 1, b);
        check("rd_data", b, mregs[mptr]);
        if (k != n - 1 && AUTOINC) mptr = (mptr + 1) % NREGS;
      end
      check("rd_busy_after_nack", busy, 0);
    end
    i2c_stop();
  endtask

  // Host keeps writing until the bus commit strobe appears, so both land in the commit cycle.
  task automatic collide(input int hidx, input logic [7:0] hdata, input logic [7:0] bdata);
    logic ack;
    bit seen;
    seen = 1'b0;
    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    send_byte(8'h03, ack);
    fork
      send_byte(bdata, ack);
      begin
        for (int c = 0; c < 400 && !seen; c++) begin
          host_we = 1'b1; host_idx = hidx[IW-1:0]; host_wdata = hdata;
          wait_clk(1);
          if (bus_wr_stb) seen = 1'b1;
        end
        host_we = 1'b0;
      end
    join
    check("col_strobe_seen", seen, 1);
    check("col_data_ack", ack, 0);
    i2c_stop();
    mregs[hidx] = hdata;
    mregs[3] = bdata;
    mptr = AUTOINC ? 4 : 3;
  endtask

  initial begin
    logic ack;
    int s0, o0, n;
    logic [6:0] a;

    foreach (mregs[i]) mregs[i] = 8'h00;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", bus_wr_stb, 0);
    check("rst_rdata", host_rdata, 0);
    reset = 1'b0;
    wait_clk(2);

    // Basic single-byte write
    s0 = stb_cnt;
    wq = '{8'hA5};
    txn_write(DEV, 8'h03);
    check("t1_stb_count", stb_cnt - s0, 1);
    check("t1_stb_idx", last_idx, 3);
    host_check("t1_reg3", 3);
    check("t1_reg3_const", host_rdata, 8'hA5);

    // Host-written value read back over the bus
    host_write(5, 8'h3C);
    txn_read(DEV, 1'b1, 8'h05, 1);

    // Wrong address must never drive SDA
    o0 = oe_cnt;
    wq = '{8'hEE};
    txn_write(7'h49, 8'h03);
    check("t3_no_oe", oe_cnt - o0, 0);
    host_check("t3_reg3", 3);

    // Address-only write leaves pointer untouched
    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    check("t_addronly_ack", ack, 0);
    i2c_stop();
    txn_read(DEV, 1'b0, 8'h00, 1);

    // Two data bytes from the last index
    wq = '{8'h11, 8'h22};
    txn_write(DEV, 8'h0F);
    host_check("t4_reg15", 15);
    host_check("t4_reg0", 0);

    // Collisions: same index (bus wins), then different index (both commit)
    collide(3, 8'h00, 8'h77);
    host_check("t6_same_idx", 3);
    collide(6, 8'h5A, 8'h88);
    host_check("t6_diff_host", 6);
    host_check("t6_diff_bus", 3);

    // Reset during the 4th data bit of a read
    host_write(2, 8'hE7);
    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte({DEV, 1'b1}, ack);
    check("t5_addr_ack", ack, 0);
    sda_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_clk(Q); scl_drv = 1'b1;
      wait_clk(2*Q); scl_drv = 1'b0;
    end
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(2);
    check("t5_oe_before_rst", sda_oe, 1);
    reset = 1'b1;
    wait_clk(1);
    check("t5_oe_after_rst", sda_oe, 0);
    check("t5_busy_after_rst", busy, 0);
    reset = 1'b0;
    foreach (mregs[i]) mregs[i] = 8'h00;
    mptr = 0;
    wait_clk(Q); scl_drv = 1'b0;
    wait_clk(Q);
    i2c_stop();
    host_check("t5_reg2_cleared", 2);
    wq = '{8'h5C};
    txn_write(DEV, 8'h01);
    host_check("t5_post_write", 1);

    // Randomised transactions against the model
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 2) == 0)
        host_write($urandom_range(0, NREGS - 1), 8'($urandom_range(0, 255)));
      a = DEV;
      if ($urandom_range(0, 4) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = 7'h49;
      end
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: begin
          wq.delete();
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
          txn_write(a, 8'($urandom_range(0, 255)));
        end
        1: txn_read(a, 1'b1, 8'($urandom_range(0, 255)), n);
        default: txn_read(a, 1'b0, 8'h00, n);
      endcase
    end

    for (int i = 0; i < NREGS; i++) host_check("final_reg", i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
